spi_controller: RTL
===================

Name: spi_controller

Overview:
SPI Mode 0 write-only controller. It is the initiating end for the onboarding SPI register interface and drives SCLK, COPI and nCS.
- Accepts one register write per valid/ready handshake.
- Serialises each write as a 16-bit frame, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Used in the bench and in the loopback/test harness to program the SPI register peripheral, which samples COPI through 2-flop synchronisers.

Parameters:
HALF_PERIOD, 4, clk cycles per SCLK half-period; legal range >= 3 so the synchronised peripheral sees every edge; default gives SCLK = clk/8.
CS_GAP, 8, minimum clk cycles nCS stays high between frames; legal >= 2.

Ports:
clk  input  1  system clock (10 MHz)
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  write request present
req_ready  output  1  controller idle, request accepted when req_valid && req_ready
req_addr  input  7  register address
req_data  input  8  register data
busy  output  1  frame or CS gap in progress
done  output  1  one-cycle pulse, frame complete
spi_sclk  output  1  SCLK, idle low
spi_copi  output  1  serial data, changes only while SCLK is low
spi_ncs  output  1  chip select, active low

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered (no combinational path from inputs to SPI pins).
- Reset values: spi_ncs=1, spi_sclk=0, spi_copi=0, done=0, busy=0, req_ready=1, state=IDLE, counters=0.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE:
  - req_ready=1.
  - On handshake at cycle T, latch the frame {1'b1, req_addr, req_data} into a 16-bit shift register and go to SETUP.
  - Later changes on req_addr/req_data do not affect the frame.
- SETUP (from T+1):
  - spi_ncs=0, spi_sclk=0, spi_copi=frame[15].
  - Hold HALF_PERIOD cycles, then go to HIGH.
- HIGH:
  - spi_sclk=1 for HALF_PERIOD cycles.
  - COPI is held stable through the whole phase.
  - Then go to LOW and increment bit_cnt.
- LOW:
  - spi_sclk=0 for HALF_PERIOD cycles.
  - On entry, spi_copi takes the next MSB.
  - After the 16th HIGH, this LOW phase is the nCS hold phase and spi_copi=0.
  - At the end of LOW: if bit_cnt<16 go to HIGH, else go to GAP.
- Frame timing: nCS is low for exactly 33*HALF_PERIOD cycles, with exactly 16 SCLK rising edges. With HALF_PERIOD=4 this is 132 cycles: spi_ncs low over T+1..T+132 and high at T+133.
- GAP:
  - spi_ncs=1; done=1 for the first GAP cycle only.
  - Stay for CS_GAP cycles, then go to IDLE.
  - req_ready returns at T+133+CS_GAP.
- busy = (state != IDLE).
- Counters:
  - Phase counter is $clog2(HALF_PERIOD)+1 bits and runs HALF_PERIOD-1 down to 0.
  - bit_cnt is 5 bits, 0..16, with no wrap.
  - Gap counter is sized for CS_GAP.
- Back-to-back requests: a request held during busy is not accepted; it is taken on the first IDLE cycle. nCS high time between frames is never less than CS_GAP.
- Addresses > 0x04 are transmitted unchanged; filtering is the peripheral's job.
- Reset mid-frame: all outputs return to reset values immediately. The partial frame is dropped with no retry. The peripheral discards it because its bit count is not 16.
- The R/W bit is always 1; reads are not supported (there is no CIPO).

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS=16, ADDR_W=7, DATA_W=8, RW_WRITE=1'b1.
  - Register address constants: REG_EN_OUT_7_0=0x00, REG_EN_OUT_15_8=0x01, REG_EN_PWM_7_0=0x02, REG_EN_PWM_15_8=0x03, REG_PWM_DUTY=0x04.
  - FSM state enum.
- One natural sub-module, spi_half_tick: reloadable down-counter that emits a tick every HALF_PERIOD cycles while enabled.

Test Plan:
- Reset, then idle 20 cycles -> spi_ncs=1, spi_sclk=0, spi_copi=0, req_ready=1, done never asserted.
- Write addr 0x04 data 0x80 -> bits on rising edges: 1,0000100,10000000; exactly 16 rising edges; nCS low 132 cycles; done pulse at T+133; looped-back peripheral pwm_duty_cycle=0x80.
- req_valid held high with two queued writes (0x00/0xFF, then 0x01/0x0F) -> second handshake at T+141; nCS high >= 8 cycles between frames; peripheral en_reg_out_7_0=0xFF, en_reg_out_15_8=0x0F.
- Assert rst_n low after the 5th SCLK rising edge of a write to 0x02 -> outputs at reset values in the same cycle; peripheral en_reg_pwm_7_0 unchanged; a following write 0x02/0x55 lands as 0x55.
- Write addr 0x7F data 0xAA -> frame 0xFFAA on the wire; all peripheral registers unchanged.
- Change req_addr/req_data every cycle during a 0x03/0x3C frame -> wire frame stays 0x833C; COPI changes only while SCLK=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: frame geometry,
// peripheral register map and controller state encoding.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  // Legacy encodings kept so existing dumps/decoders stay valid.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    HIGH  = ST_HIGH,
    LOW   = ST_LOW,
    GAP   = ST_GAP
  } state_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {RW_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Reloadable down-counter producing a one-cycle tick every HALF_PERIOD
// enabled clocks; paces each SCLK half-period.
module spi_half_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 write-only initiator: one 16-bit {R/W, addr, data} frame per
// valid/ready handshake, MSB first, with a guaranteed nCS-high gap.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_copi,
  output logic              spi_ncs
);

  localparam int GW = $clog2(CS_GAP) + 1;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  accept;
  logic                  phase_en;
  logic                  tick;

  assign accept   = req_valid && req_ready;
  assign phase_en = state inside {SETUP, HIGH, LOW};

  spi_half_tick #(.HALF_PERIOD(HALF_PERIOD)) u_half_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (phase_en),
    .tick  (tick)
  );

  // COPI is the shift register MSB; zeros shifted in give the low hold phase.
  assign spi_copi = shreg[FRAME_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_ncs   <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SETUP;
            shreg     <= make_frame(req_addr, req_data);
            bit_cnt   <= '0;
            spi_ncs   <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            state    <= HIGH;
            spi_sclk <= 1'b1;
          end
        end
        HIGH: begin
          if (tick) begin
            state    <= LOW;
            spi_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + 5'd1;
            shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
          end
        end
        LOW: begin
          if (tick) begin
            if (bit_cnt < 5'(FRAME_BITS)) begin
              state    <= HIGH;
              spi_sclk <= 1'b1;
            end else begin
              state   <= GAP;
              spi_ncs <= 1'b1;
              done    <= 1'b1;
              gap_cnt <= GW'(CS_GAP - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
